wb_mem_arbiter: RTL
===================

// Module: wb_mem_arbiter
// PURPOSE
// Shares one Wishbone-classic memory port (the Memory instance in verification_top)
// between two requesters: m0 = instruction fetch, m1 = data load/store.
// Used when ENABLE_SECOND_MEMORY is off and the core exposes split I/D buses.
// Round-robin arbitration, one transaction per grant, plus a per-grant ack timeout.
// PARAMETERS
// ADDR_WIDTH      32   address width on all buses
// DATA_WIDTH      32   data width on all buses
// TIMEOUT_CYCLES  255  cycles in a grant without s_ack before abort; 0 = timeout disabled
// PORTS
// clk         in   1           system clock
// rst         in   1           synchronous reset, active-high
// m0_cyc      in   1           requester 0 bus cycle
// m0_stb      in   1           requester 0 strobe
// m0_we       in   1           requester 0 write enable
// m0_addr     in   ADDR_WIDTH  requester 0 address
// m0_data_i   in   DATA_WIDTH  requester 0 write data
// m0_data_o   out  DATA_WIDTH  requester 0 read data
// m0_ack      out  1           requester 0 acknowledge
// m0_err      out  1           requester 0 timeout error, 1-cycle pulse
// m1_*        ---  ---         same set as m0_*, for requester 1
// s_cyc       out  1           memory bus cycle
// s_stb       out  1           memory strobe
// s_we        out  1           memory write enable
// s_addr      out  ADDR_WIDTH  memory address
// s_data_o    out  DATA_WIDTH  memory write data
// s_data_i    in   DATA_WIDTH  memory read data
// s_ack       in   1           memory acknowledge
// grant       out  2           one-hot current owner; 00 = idle
// BEHAVIOUR
// - Request: reqN = mN_cyc & mN_stb.
// - State machine (registered): IDLE, GRANT0, GRANT1. last_grant is a 1-bit register.
// - Reset: state=IDLE, last_grant=1 so m0 wins the first tie, timeout count=0.
//   All outputs are 0 while rst is high and in the cycle after it.
// - IDLE: only one request -> grant it. Both -> grant !last_grant.
//   Grant is registered: request in cycle N -> s_stb in cycle N+1.
// - GRANTx outputs (combinational from state):
//   s_cyc/s_stb/s_we/s_addr/s_data_o = mx_*. mx_ack = s_ack. mx_data_o = s_data_i.
//   The other requester sees ack=0, err=0, data_o=0.
// - IDLE outputs: all s_* = 0, all m*_ack/err = 0, all m*_data_o = 0.
// - GRANTx, s_ack=1: transaction complete. Set last_grant=x.
//   If the other requester requests this cycle, go directly to GRANT(other) with no idle bubble.
//   Otherwise go to IDLE. A master that still asserts stb in the ack cycle re-arbitrates from IDLE.
// - GRANTx, mx_cyc=0 (abandon): go to IDLE next cycle. No ack is forwarded.
//   last_grant is unchanged.
// - Timeout: count resets to 0 on every grant entry and increments each GRANT cycle without s_ack.
//   When count == TIMEOUT_CYCLES-1 and s_ack=0: mx_err=1 that cycle, set last_grant=x,
//   go to IDLE (s_cyc drops next cycle). The count saturates; it never wraps.
// - Simultaneous s_ack and timeout terminal count: ack wins, no err.
// - Simultaneous s_ack and mx_cyc drop: ack is forwarded and completes normally.
// - Ack arriving while IDLE (stale) is ignored and not forwarded.
// - Reset mid-transaction: abort immediately. No ack or err is generated; the memory sees s_cyc=0.
// STRUCTURE
// - Package wb_arb_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT0, ARB_GRANT1} arb_state_t;
//   localparams GRANT_NONE=2'b00, GRANT_M0=2'b01, GRANT_M1=2'b10.
// - Sub-module wb_arb_timeout: loadable saturating counter (clr, en, terminal-count out),
//   width $clog2(TIMEOUT_CYCLES+1). Tied off when TIMEOUT_CYCLES=0.
// - Top: FSM, last_grant register, output mux.
// TESTING
// 1. m0 read 0x100 alone, memory acks 2 cycles after stb with 0xDEADBEEF
//    -> m0_ack=1 for 1 cycle with m0_data_o=0xDEADBEEF; m1_ack=0; grant=01 then 00.
// 2. m0 read 0x100 and m1 write 0x200=0x12345678 requested together out of reset
//    -> m0 served first; grant goes 01->10 in the cycle after m0's ack; memory word 0x200 = 0x12345678.
// 3. Both masters request continuously for 4 transactions -> grant order 01,10,01,10;
//    each master gets exactly 2 acks.
// 4. TIMEOUT_CYCLES=8, m1 request, memory never acks -> m1_err pulses in the 8th grant cycle;
//    s_cyc=0 next cycle; m0_err stays 0.
// 5. m1 granted, drops cyc before ack -> state IDLE next cycle; late s_ack not forwarded to either master.
// 6. rst=1 during GRANT1 -> next cycle grant=00, all outputs 0; after release,
//    tied request -> m0 granted.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT0, ARB_GRANT1} arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  function automatic logic [1:0] state_to_grant(input arb_state_t st);
    case (st)
      ARB_GRANT0: return GRANT_M0;
      ARB_GRANT1: return GRANT_M1;
      default:    return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Per-grant ack timeout: saturating cycle counter with terminal-count flag.
module wb_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign tc = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count;

      // Holds at the terminal value instead of wrapping.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          count <= '0;
        end else if (en && (count != TC_VAL)) begin
          count <= count + 1'b1;
        end
      end

      assign tc = (count == TC_VAL);
    end
  endgenerate

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone-classic memory port between
// instruction fetch (m0) and data access (m1), one transaction per grant.
//
// state      | meaning
// ARB_IDLE   | no owner, memory bus quiet, arbitrating pending requests
// ARB_GRANT0 | m0 owns the memory bus until ack, abandon or timeout
// ARB_GRANT1 | m1 owns the memory bus until ack, abandon or timeout
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack,
  output logic [1:0]            grant
);

  arb_state_t state;
  arb_state_t state_next;
  logic       last_grant;
  logic       last_grant_next;
  logic       req0;
  logic       req1;
  logic       tmr_clr;
  logic       tmr_en;
  logic       tmr_tc;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  // Count restarts whenever ownership changes, so each grant gets a full budget.
  assign tmr_clr = (state == ARB_IDLE) || (state_next != state);
  assign tmr_en  = (state != ARB_IDLE) && !s_ack;

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    unique case (state)
      ARB_IDLE: begin
        if (req0 && (!req1 || last_grant)) begin
          state_next = ARB_GRANT0;
        end else if (req1) begin
          state_next = ARB_GRANT1;
        end
      end
      ARB_GRANT0: begin
        if (s_ack) begin
          last_grant_next = 1'b0;
          state_next      = req1 ? ARB_GRANT1 : ARB_IDLE;
        end else if (!m0_cyc) begin
          state_next = ARB_IDLE;
        end else if (tmr_tc) begin
          last_grant_next = 1'b0;
          state_next      = ARB_IDLE;
        end
      end
      ARB_GRANT1: begin
        if (s_ack) begin
          last_grant_next = 1'b1;
          state_next      = req0 ? ARB_GRANT0 : ARB_IDLE;
        end else if (!m1_cyc) begin
          state_next = ARB_IDLE;
        end else if (tmr_tc) begin
          last_grant_next = 1'b1;
          state_next      = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Gated by rst so a reset mid-transaction drops the bus in the same cycle.
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_addr    = '0;
    s_data_o  = '0;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m0_data_o = '0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m1_data_o = '0;
    grant     = GRANT_NONE;
    if (!rst) begin
      grant = state_to_grant(state);
      unique case (state)
        ARB_GRANT0: begin
          s_cyc     = m0_cyc;
          s_stb     = m0_stb;
          s_we      = m0_we;
          s_addr    = m0_addr;
          s_data_o  = m0_data_i;
          m0_ack    = s_ack;
          m0_err    = m0_cyc & tmr_tc & ~s_ack;
          m0_data_o = s_data_i;
        end
        ARB_GRANT1: begin
          s_cyc     = m1_cyc;
          s_stb     = m1_stb;
          s_we      = m1_we;
          s_addr    = m1_addr;
          s_data_o  = m1_data_i;
          m1_ack    = s_ack;
          m1_err    = m1_cyc & tmr_tc & ~s_ack;
          m1_data_o = s_data_i;
        end
        default: ;
      endcase
    end
  end

endmodule
